i2c_slave_mem: RTL and testbench

I2C responder (target) with an internal byte memory. It is the bus-side counterpart of the team's `top_I2C` master. The master's 7-bit address field selects a memory location, and each transaction carries one data byte, either written to that location or read from it. The block oversamples SCL/SDA in the system clock domain and drives SDA open-drain.

---
 rtl/i2c_slave_mem.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_i2c_slave_mem.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_mem.sv
// -----------------------------------------------------------------------------
// i2c_slave_mem
//
// I2C target with an internal byte memory. The 7-bit address field of each
// transaction selects a memory location. One data byte follows, and it is
// either written to that location or read from it. SCL and SDA are
// oversampled in the clk domain. SDA is driven open-drain through sda_oe.
//
// Optional feature macro: I2C_SLV_AUTOINC_EN
//   defined   -> burst transfers. The pointer advances after every data byte
//                and wraps from MEM_DEPTH-1 to 0. A read burst continues while
//                the master ACKs.
//   undefined -> exactly one data byte per transaction.
//
// Parameters
//   MEM_DEPTH  number of 8-bit locations (1..128); addresses >= MEM_DEPTH NACK
//
// Ports
//   clk        system clock (sole clock)
//   rst_n      asynchronous active-low reset
//   scl        bus SCL, asynchronous
//   sda_i      sampled bus SDA, asynchronous
//   sda_oe     1 pulls SDA low, 0 releases it
//   busy       high from detected START until detected STOP
//   done       one-cycle pulse at a STOP that ends an ACKed transaction
//   last_addr  address of the last ACKed transaction
//   last_op    R/W bit of the last ACKed transaction (1 = read)
// -----------------------------------------------------------------------------
module i2c_slave_mem #(
    parameter int MEM_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic [6:0] last_addr,
    output logic       last_op
);

    localparam int         PTR_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [7:0] DEPTH_8 = 8'(MEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_WAIT_STOP
    } state_e;

    // ------------------------------------------------------------------
    // Input conditioning: 2-FF synchronizer plus one history stage.
    // The stages reset to 1 (idle bus), so the release of reset does not
    // create a false edge.
    // ------------------------------------------------------------------
    logic scl_m_q, scl_s_q, scl_h_q;
    logic sda_m_q, sda_s_q, sda_h_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_m_q <= 1'b1;
            scl_s_q <= 1'b1;
            scl_h_q <= 1'b1;
            sda_m_q <= 1'b1;
            sda_s_q <= 1'b1;
            sda_h_q <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // stage samples the pre-edge value of the stage before it.
            scl_m_q <= scl;
            scl_s_q <= scl_m_q;
            scl_h_q <= scl_s_q;
            sda_m_q <= sda_i;
            sda_s_q <= sda_m_q;
            sda_h_q <= sda_s_q;
        end
    end

    logic scl_rise, scl_fall, bus_start, bus_stop;

    assign scl_rise  =  scl_s_q & ~scl_h_q;
    assign scl_fall  = ~scl_s_q &  scl_h_q;
    // START and STOP are SDA edges while SCL is stably high.
    assign bus_start = scl_s_q & scl_h_q &  sda_h_q & ~sda_s_q;
    assign bus_stop  = scl_s_q & scl_h_q & ~sda_h_q &  sda_s_q;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             sda_oe_q, sda_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             acked_q, acked_d;     // current transaction's address was ACKed
    logic             ack_on_q, ack_on_d;   // second phase of an ACK bit
    logic [6:0]       last_addr_q, last_addr_d;
    logic             last_op_q, last_op_d;

    logic [7:0]       mem_q [MEM_DEPTH];
    logic [7:0]       mem_rd;
    logic [7:0]       mem_wdata;
    logic             mem_we;
    logic             last_bit;
    logic             addr_ok;

    assign mem_rd    = mem_q[ptr_q];
    assign mem_wdata = {shift_q[6:0], sda_s_q};
    assign last_bit  = (bit_cnt_q == 3'd7);
    assign addr_ok   = ({1'b0, shift_q[6:0]} < DEPTH_8);

`ifdef I2C_SLV_AUTOINC_EN
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MEM_DEPTH - 1);
    logic [PTR_W-1:0] ptr_inc;
    logic [7:0]       mem_inc;

    assign ptr_inc = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    assign mem_inc = mem_q[ptr_inc];
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next state. STOP and START override every state.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first, so no
        // path through the block leaves it unassigned and infers a latch.
        state_d = state_q;
        if (bus_stop) begin
            state_d = S_IDLE;
        end else if (bus_start) begin
            state_d = S_ADDR;
        end else begin
            case (state_q)
                S_ADDR:
                    if (scl_rise && last_bit) state_d = addr_ok ? S_ADDR_ACK : S_WAIT_STOP;
                S_ADDR_ACK:
                    if (scl_fall && ack_on_q) state_d = last_op_q ? S_RD_DATA : S_WR_DATA;
                S_WR_DATA:
                    if (scl_rise && last_bit) state_d = S_WR_ACK;
                S_WR_ACK:
`ifdef I2C_SLV_AUTOINC_EN
                    if (scl_fall && ack_on_q) state_d = S_WR_DATA;
`else
                    if (scl_fall && ack_on_q) state_d = S_WAIT_STOP;
`endif
                S_RD_DATA:
                    if (scl_fall && last_bit) state_d = S_RD_ACK;
                S_RD_ACK:
`ifdef I2C_SLV_AUTOINC_EN
                    if (scl_rise && sda_s_q)       state_d = S_WAIT_STOP;
                    else if (scl_fall && ack_on_q) state_d = S_RD_DATA;
`else
                    if (scl_rise) state_d = S_WAIT_STOP;
`endif
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs and datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        acked_d     = acked_q;
        ack_on_d    = ack_on_q;
        last_addr_d = last_addr_q;
        last_op_d   = last_op_q;
        mem_we      = 1'b0;

        if (bus_stop) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = busy_q & acked_q;
            acked_d  = 1'b0;
            ack_on_d = 1'b0;
        end else if (bus_start) begin
            // A repeated START also lands here; any partial byte is dropped.
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
            bit_cnt_d = 3'd0;
            ack_on_d  = 1'b0;
            acked_d   = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s_q};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit && addr_ok) begin
                            ptr_d       = shift_q[PTR_W-1:0];
                            last_addr_d = shift_q[6:0];
                            last_op_d   = sda_s_q;
                            acked_d     = 1'b1;
                        end
                    end
                end
                // ACK bit: the first SCL fall pulls SDA low, the next one
                // ends the 9th clock and sets up the following phase.
                S_ADDR_ACK, S_WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_on_q) begin
                            sda_oe_d = 1'b1;
                            ack_on_d = 1'b1;
                        end else begin
                            ack_on_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                            sda_oe_d  = 1'b0;
                            if (state_q == S_ADDR_ACK && last_op_q) begin
                                shift_d  = {mem_rd[6:0], 1'b1};
                                sda_oe_d = ~mem_rd[7];
                            end
`ifdef I2C_SLV_AUTOINC_EN
                            if (state_q == S_WR_ACK) ptr_d = ptr_inc;
`endif
                        end
                    end
                end
                S_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s_q};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        mem_we    = last_bit;
                    end
                end
                // Bit 7 is already on the bus; each fall presents the next
                // bit, and the 8th fall releases SDA for the master's ACK.
                S_RD_DATA: begin
                    if (scl_fall) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            sda_oe_d = ~shift_q[7];
                            shift_d  = {shift_q[6:0], 1'b1};
                        end
                    end
                end
`ifdef I2C_SLV_AUTOINC_EN
                S_RD_ACK: begin
                    if (scl_rise && !sda_s_q) begin
                        ack_on_d = 1'b1;
                    end else if (scl_fall && ack_on_q) begin
                        ack_on_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        ptr_d     = ptr_inc;
                        shift_d   = {mem_inc[6:0], 1'b1};
                        sda_oe_d  = ~mem_inc[7];
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            acked_q     <= 1'b0;
            ack_on_q    <= 1'b0;
            last_addr_q <= '0;
            last_op_q   <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            acked_q     <= acked_d;
            ack_on_q    <= ack_on_d;
            last_addr_q <= last_addr_d;
            last_op_q   <= last_op_d;
        end
    end

    // ------------------------------------------------------------------
    // Byte memory
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the memory must read 0x00 after reset, so it is built
            // from resettable flops rather than a RAM macro.
            for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= 8'h00;
        end else if (mem_we) begin
            mem_q[ptr_q] <= mem_wdata;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign last_addr = last_addr_q;
    assign last_op   = last_op_q;

endmodule

// File: tb/tb_i2c_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave_mem
//
// Self-checking bench for i2c_slave_mem with MEM_DEPTH = 16. A behavioural I2C
// master drives SCL and SDA with 10-clk high and low phases. SDA is
// modelled as a wired-AND of the master and the DUT. A table of single-byte
// transactions is applied in a loop. Hand-written sequences then cover the
// repeated START, reset during a read, and a two-byte burst. Expected values
// in the burst sequence depend on whether I2C_SLV_AUTOINC_EN is defined.
// -----------------------------------------------------------------------------
module tb_i2c_slave_mem;

    localparam int MEM_DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic       busy;
    logic       done;
    logic [6:0] last_addr;
    logic       last_op;

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_mem #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl       (scl),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .busy      (busy),
        .done      (done),
        .last_addr (last_addr),
        .last_op   (last_op)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Bus-side monitors, sampled on the falling clk edge
    int   done_cnt      = 0;
    int   done_bad      = 0;
    int   busy_fall_cnt = 0;
    logic busy_prev     = 1'b0;

    always @(negedge clk) begin
        if (done && (busy || !busy_prev)) done_bad++;
        if (done) done_cnt++;
        if (busy_prev && !busy) busy_fall_cnt++;
        busy_prev = busy;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- master bit-level model ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_clk(5);
        scl   = 1'b1; wait_clk(10);
        sda_m = 1'b0; wait_clk(10);
        scl   = 1'b0; wait_clk(5);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clk(5);
        scl   = 1'b1; wait_clk(10);
        sda_m = 1'b1; wait_clk(10);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_clk(5);
        scl   = 1'b1; wait_clk(10);
        scl   = 1'b0; wait_clk(5);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wait_clk(5);
        scl   = 1'b1; wait_clk(5);
        b     = sda_line; wait_clk(5);
        scl   = 1'b0; wait_clk(5);
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic recv_byte(output logic [7:0] v);
        logic b;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            recv_bit(b);
            v = {v[6:0], b};
        end
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d,
                            output logic aack, output logic dack);
        bus_start();
        send_byte({a, 1'b0}, aack);
        send_byte(d, dack);
        bus_stop();
    endtask

    task automatic do_read(input logic [6:0] a, output logic aack, output logic [7:0] d);
        bus_start();
        send_byte({a, 1'b1}, aack);
        recv_byte(d);
        send_bit(1'b1);                 // master NACK ends the read
        bus_stop();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         rd;
        logic [6:0] addr;
        logic [7:0] wdata;
        bit         exp_aack;
        bit         exp_dack;
        logic [7:0] exp_rdata;
        int         exp_done;
        logic [6:0] exp_la;
        bit         exp_lo;
    } vec_t;

    function automatic vec_t vw(input logic [6:0] a, input logic [7:0] d, input bit ok,
                                input logic [6:0] la, input bit lo);
        vec_t v;
        v.rd = 1'b0; v.addr = a; v.wdata = d; v.exp_aack = ok; v.exp_dack = ok;
        v.exp_rdata = 8'h00; v.exp_done = ok ? 1 : 0; v.exp_la = la; v.exp_lo = lo;
        return v;
    endfunction

    function automatic vec_t vr(input logic [6:0] a, input logic [7:0] d, input bit ok,
                                input logic [6:0] la, input bit lo);
        vec_t v;
        v.rd = 1'b1; v.addr = a; v.wdata = 8'h00; v.exp_aack = ok; v.exp_dack = 1'b0;
        v.exp_rdata = d; v.exp_done = ok ? 1 : 0; v.exp_la = la; v.exp_lo = lo;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        logic       aack, dack, b;
        logic [7:0] rdata;
        int         d0, f0;

        vecs.push_back(vw(7'd3, 8'h05, 1'b1, 7'd3, 1'b0));
        vecs.push_back(vr(7'd3, 8'h05, 1'b1, 7'd3, 1'b1));
        vecs.push_back(vr(7'd2, 8'h00, 1'b1, 7'd2, 1'b1));   // never written
        for (int i = 1; i <= 5; i++) vecs.push_back(vw(7'(i), 8'(i), 1'b1, 7'(i), 1'b0));
        for (int i = 1; i <= 5; i++) vecs.push_back(vr(7'(i), 8'(i), 1'b1, 7'(i), 1'b1));
        vecs.push_back(vw(7'd6, 8'hC3, 1'b1, 7'd6, 1'b0));
        vecs.push_back(vr(7'd6, 8'hC3, 1'b1, 7'd6, 1'b1));
        // Out-of-range address: NACK, no done, last_* unchanged
        vecs.push_back(vw(7'h7F, 8'h5A, 1'b0, 7'd6, 1'b1));
        vecs.push_back(vr(7'h7F, 8'hFF, 1'b0, 7'd6, 1'b1));
        vecs.push_back(vr(7'd15, 8'h00, 1'b1, 7'd15, 1'b1)); // 0x7F did not alias to 15

        // ---------------- reset ----------------
        rst_n = 1'b0;
        scl   = 1'b1;
        sda_m = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        check("rst_sda_oe",    sda_oe,    0);
        check("rst_busy",      busy,      0);
        check("rst_done",      done,      0);
        check("rst_last_addr", last_addr, 0);
        check("rst_last_op",   last_op,   0);

        // ---------------- table-driven transactions ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            d0 = done_cnt;
            if (vecs[i].rd) begin
                do_read(vecs[i].addr, aack, rdata);
                check($sformatf("v%0d_aack", i),  aack,  vecs[i].exp_aack);
                check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            end else begin
                do_write(vecs[i].addr, vecs[i].wdata, aack, dack);
                check($sformatf("v%0d_aack", i), aack, vecs[i].exp_aack);
                check($sformatf("v%0d_dack", i), dack, vecs[i].exp_dack);
            end
            check($sformatf("v%0d_done", i),      done_cnt - d0, vecs[i].exp_done);
            check($sformatf("v%0d_last_addr", i), last_addr,     vecs[i].exp_la);
            check($sformatf("v%0d_last_op", i),   last_op,       vecs[i].exp_lo);
            check($sformatf("v%0d_busy", i),      busy,          0);
        end

        // ---------------- repeated START mid-write ----------------
        d0 = done_cnt;
        f0 = busy_fall_cnt;
        bus_start();
        send_byte({7'd1, 1'b0}, aack);
        check("rs_wr_aack", aack, 1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        check("rs_busy_before", busy, 1);
        bus_start();
        check("rs_busy_after", busy, 1);
        check("rs_no_busy_drop", busy_fall_cnt - f0, 0);
        send_byte({7'd1, 1'b1}, aack);
        check("rs_rd_aack", aack, 1);
        recv_byte(rdata);
        check("rs_rdata", rdata, 8'h01);          // partial byte discarded
        send_bit(1'b1);
        bus_stop();
        check("rs_done", done_cnt - d0, 1);
        check("rs_last_op", last_op, 1);

        // ---------------- reset while driving bit 5 of a read ----------------
        d0 = done_cnt;
        bus_start();
        send_byte({7'd6, 1'b1}, aack);
        check("rr_aack", aack, 1);
        recv_bit(b); check("rr_bit7", b, 1);
        recv_bit(b); check("rr_bit6", b, 1);
        check("rr_oe_bit5", sda_oe, 1);           // bit 5 of 0xC3 is 0
        rst_n = 1'b0;
        #1;
        check("rr_oe_async", sda_oe, 0);
        check("rr_busy_async", busy, 0);
        check("rr_last_addr", last_addr, 0);
        wait_clk(2);
        rst_n = 1'b1;
        recv_bit(b); check("rr_ignored", b, 1);
        for (int i = 0; i < 4; i++) recv_bit(b);
        send_bit(1'b1);
        bus_stop();
        check("rr_no_done", done_cnt - d0, 0);
        do_read(7'd6, aack, rdata);
        check("rr_cleared", rdata, 8'h00);
        do_write(7'd6, 8'h3C, aack, dack);
        check("rr_wr_aack", aack, 1);
        check("rr_wr_dack", dack, 1);
        do_read(7'd6, aack, rdata);
        check("rr_rd_data", rdata, 8'h3C);
        check("rr_done", done_cnt - d0, 3);

        // ---------------- two-byte write at the top address ----------------
        d0 = done_cnt;
        bus_start();
        send_byte({7'd15, 1'b0}, aack);
        check("bw_aack", aack, 1);
        send_byte(8'hAA, dack);
        check("bw_ack1", dack, 1);
        send_byte(8'hBB, dack);
`ifdef I2C_SLV_AUTOINC_EN
        check("bw_ack2", dack, 1);
`else
        check("bw_ack2", dack, 0);
`endif
        bus_stop();
        check("bw_done", done_cnt - d0, 1);
        do_read(7'd15, aack, rdata);
        check("bw_mem15", rdata, 8'hAA);
        do_read(7'd0, aack, rdata);
`ifdef I2C_SLV_AUTOINC_EN
        check("bw_mem0", rdata, 8'hBB);
`else
        check("bw_mem0", rdata, 8'h00);
`endif

        wait_clk(4);
        check("done_shape", done_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
